// File: rtl/vu_meter.sv
// Stereo VU meter: tracks the louder channel's peak magnitude with hold and
// linear decay, and drives an 8-LED thermometer bar at 6 dB per LED.
module vu_meter #(
    parameter int unsigned HOLD_SMPLS  = 4800,
    parameter int unsigned DECAY_SMPLS = 48,
    parameter int unsigned DECAY_STEP  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    // vld is a one-cycle strobe with no back-pressure: a sample pair is
    // consumed on every cycle vld=1, and nothing changes on cycles vld=0.
    input  logic        vld,
    input  logic [15:0] lft_chnnl,
    input  logic [15:0] rght_chnnl,
    output logic [7:0]  LED,
    output logic [1:0]  dbg_state_o,
    output logic [14:0] dbg_peak_o,
    output logic [15:0] dbg_hold_cnt_o,
    output logic [15:0] dbg_decay_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } state_e;

    localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_SMPLS - 1);
    localparam logic [15:0] DECAY_LAST  = 16'(DECAY_SMPLS - 1);
    localparam logic [15:0] STEP        = 16'(DECAY_STEP);

    state_e      state_q, state_d;
    logic [14:0] peak_q, peak_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [15:0] decay_cnt_q, decay_cnt_d;
    logic [7:0]  led_q, led_d;

    logic [14:0] lft_mag, rght_mag, mag;
    logic        trigger;

    // |x| with -32768 clamped to 32767 so the magnitude fits in 15 bits.
    function automatic logic [14:0] abs_sat(input logic [15:0] x);
        if (!x[15])
            return x[14:0];
        else if (x[14:0] == 15'd0)
            return 15'h7FFF;
        else
            return ~x[14:0] + 15'd1;
    endfunction

    assign lft_mag  = abs_sat(lft_chnnl);
    assign rght_mag = abs_sat(rght_chnnl);
    assign mag      = (lft_mag > rght_mag) ? lft_mag : rght_mag;
    assign trigger  = vld && (mag != 15'd0) && (mag >= peak_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            peak_q      <= '0;
            hold_cnt_q  <= '0;
            decay_cnt_q <= '0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            hold_cnt_q  <= hold_cnt_d;
            decay_cnt_q <= decay_cnt_d;
            led_q       <= led_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        hold_cnt_d  = hold_cnt_q;
        decay_cnt_d = decay_cnt_q;
        if (trigger) begin
            // A new peak beats any hold expiry or decay step on the same sample.
            state_d     = HOLD;
            peak_d      = mag;
            hold_cnt_d  = HOLD_RELOAD;
            decay_cnt_d = '0;
        end else if (vld) begin
            case (state_q)
                HOLD: begin
                    if (hold_cnt_q == 16'd0) begin
                        state_d     = DECAY;
                        decay_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 16'd1;
                    end
                end
                DECAY: begin
                    if (decay_cnt_q == DECAY_LAST) begin
                        decay_cnt_d = '0;
                        if ({1'b0, peak_q} > STEP) begin
                            peak_d = peak_q - STEP[14:0];
                        end else begin
                            peak_d  = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        decay_cnt_d = decay_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // LED[i] lights once peak reaches 2^(7+i); monotone thresholds keep it a thermometer.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < 8; i++) begin
            led_d[i] = ({1'b0, peak_q} >= (16'd1 << (7 + i)));
        end
    end

    assign LED             = led_q;
    assign dbg_state_o     = state_q;
    assign dbg_peak_o      = peak_q;
    assign dbg_hold_cnt_o  = hold_cnt_q;
    assign dbg_decay_cnt_o = decay_cnt_q;

endmodule

// File: tb/tb_vu_meter.sv
// Directed and randomized checks of vu_meter with default parameters
// (hold 4800 samples, decay step 64 every 48 samples).
module tb_vu_meter;

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic [15:0] lft_chnnl;
    logic [15:0] rght_chnnl;
    logic [7:0]  LED;
    logic [1:0]  dbg_state_o;
    logic [14:0] dbg_peak_o;
    logic [15:0] dbg_hold_cnt_o;
    logic [15:0] dbg_decay_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DECAY = 2'd2;

    vu_meter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vld             (vld),
        .lft_chnnl       (lft_chnnl),
        .rght_chnnl      (rght_chnnl),
        .LED             (LED),
        .dbg_state_o     (dbg_state_o),
        .dbg_peak_o      (dbg_peak_o),
        .dbg_hold_cnt_o  (dbg_hold_cnt_o),
        .dbg_decay_cnt_o (dbg_decay_cnt_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // drivers: one vld pulse, returning at the negedge after it was sampled
    task automatic send(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        vld = 1'b1; lft_chnnl = l; rght_chnnl = r;
        @(negedge clk);
        vld = 1'b0; lft_chnnl = '0; rght_chnnl = '0;
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vld = 1'b1; lft_chnnl = '0; rght_chnnl = '0;
        end
        @(negedge clk);
        vld = 1'b0;
    endtask

    function automatic int absv(input logic [15:0] x);
        int v;
        v = $signed(x);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic logic [7:0] thermo(input int p);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = (p >= (1 << (7 + i)));
        return t;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; vld = 1'b0; lft_chnnl = '0; rght_chnnl = '0;
        #2;
        total++; if (LED !== 8'h00) begin bad++; $display("FAIL reset_led got=%h want=00", LED); end
        total++; if (dbg_state_o !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state_o); end
        total++; if (dbg_peak_o !== 15'd0) begin bad++; $display("FAIL reset_peak got=%0d want=0", dbg_peak_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send(16'h0100, 16'hFF00);
        total++; if (dbg_peak_o !== 15'd256) begin bad++; $display("FAIL basic_peak got=%0d want=256", dbg_peak_o); end
        total++; if (LED !== 8'h00) begin bad++; $display("FAIL basic_led_latency got=%b want=00000000", LED); end
        total++; if (dbg_hold_cnt_o !== 16'd4799) begin bad++; $display("FAIL basic_hold got=%0d want=4799", dbg_hold_cnt_o); end
        @(negedge clk);
        total++; if (LED !== 8'b0000_0011) begin bad++; $display("FAIL basic_led got=%b want=00000011", LED); end
    endtask

    task automatic test_full_scale();
        send(16'h8000, 16'h0000);
        total++; if (dbg_peak_o !== 15'd32767) begin bad++; $display("FAIL fs_peak got=%0d want=32767", dbg_peak_o); end
        @(negedge clk);
        total++; if (LED !== 8'hFF) begin bad++; $display("FAIL fs_led got=%h want=ff", LED); end
        zeros(4799);
        total++; if (LED !== 8'hFF) begin bad++; $display("FAIL fs_hold_led got=%h want=ff", LED); end
        total++; if (dbg_state_o !== S_HOLD) begin bad++; $display("FAIL fs_hold_state got=%0d want=1", dbg_state_o); end
        total++; if (dbg_hold_cnt_o !== 16'd0) begin bad++; $display("FAIL fs_hold_cnt got=%0d want=0", dbg_hold_cnt_o); end
        zeros(1);
        total++; if (dbg_state_o !== S_DECAY) begin bad++; $display("FAIL fs_decay_state got=%0d want=2", dbg_state_o); end
        total++; if (dbg_peak_o !== 15'd32767) begin bad++; $display("FAIL fs_decay_peak got=%0d want=32767", dbg_peak_o); end
    endtask

    task automatic test_thresholds();
        logic [15:0] vals [6];
        logic [7:0]  leds [6];
        vals = '{16'd127, 16'd128, 16'd255, 16'd256, 16'd16383, 16'd16384};
        leds = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h7F, 8'hFF};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            send(16'h0000, vals[i]);
            @(negedge clk);
            total++;
            if (LED !== leds[i]) begin
                bad++; $display("FAIL thresh_%0d got=%b want=%b", vals[i], LED, leds[i]);
            end
        end
    endtask

    task automatic test_decay();
        apply_reset();
        send(16'd200, 16'h0000);
        @(negedge clk);
        total++; if (LED !== 8'h01) begin bad++; $display("FAIL decay_start_led got=%h want=01", LED); end
        zeros(4800);
        total++; if (dbg_state_o !== S_DECAY) begin bad++; $display("FAIL decay_enter got=%0d want=2", dbg_state_o); end
        zeros(47);
        total++; if (dbg_peak_o !== 15'd200) begin bad++; $display("FAIL decay_47 got=%0d want=200", dbg_peak_o); end
        zeros(1);
        total++; if (dbg_peak_o !== 15'd136) begin bad++; $display("FAIL decay_step1 got=%0d want=136", dbg_peak_o); end
        @(negedge clk);
        total++; if (LED !== 8'h01) begin bad++; $display("FAIL decay_led1 got=%h want=01", LED); end
        zeros(48);
        total++; if (dbg_peak_o !== 15'd72) begin bad++; $display("FAIL decay_step2 got=%0d want=72", dbg_peak_o); end
        @(negedge clk);
        total++; if (LED !== 8'h00) begin bad++; $display("FAIL decay_led2 got=%h want=00", LED); end
        zeros(48);
        total++; if (dbg_peak_o !== 15'd8) begin bad++; $display("FAIL decay_step3 got=%0d want=8", dbg_peak_o); end
        zeros(48);
        total++; if (dbg_peak_o !== 15'd0) begin bad++; $display("FAIL decay_step4 got=%0d want=0", dbg_peak_o); end
        total++; if (dbg_state_o !== S_IDLE) begin bad++; $display("FAIL decay_idle got=%0d want=0", dbg_state_o); end
        zeros(5);
        total++; if (dbg_state_o !== S_IDLE) begin bad++; $display("FAIL idle_stay got=%0d want=0", dbg_state_o); end
    endtask

    task automatic test_trigger_wins();
        send(16'h0000, 16'hFC18);
        zeros(4800);
        zeros(47);
        total++; if (dbg_decay_cnt_o !== 16'd47) begin bad++; $display("FAIL tw_cnt got=%0d want=47", dbg_decay_cnt_o); end
        send(16'd1000, 16'h0000);
        total++; if (dbg_state_o !== S_HOLD) begin bad++; $display("FAIL tw_state got=%0d want=1", dbg_state_o); end
        total++; if (dbg_peak_o !== 15'd1000) begin bad++; $display("FAIL tw_peak got=%0d want=1000", dbg_peak_o); end
        total++; if (dbg_hold_cnt_o !== 16'd4799) begin bad++; $display("FAIL tw_hold got=%0d want=4799", dbg_hold_cnt_o); end
        send(16'd999, 16'd0);
        total++; if (dbg_peak_o !== 15'd1000) begin bad++; $display("FAIL below_peak got=%0d want=1000", dbg_peak_o); end
        total++; if (dbg_hold_cnt_o !== 16'd4798) begin bad++; $display("FAIL below_hold got=%0d want=4798", dbg_hold_cnt_o); end
        zeros(4798);
        send(16'd1000, 16'd0);
        total++; if (dbg_state_o !== S_HOLD) begin bad++; $display("FAIL expiry_tw_state got=%0d want=1", dbg_state_o); end
        total++; if (dbg_hold_cnt_o !== 16'd4799) begin bad++; $display("FAIL expiry_tw_hold got=%0d want=4799", dbg_hold_cnt_o); end
    endtask

    task automatic test_stall_and_reset();
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            vld = 1'b0;
            lft_chnnl  = 16'($urandom_range(0, 65535));
            rght_chnnl = 16'($urandom_range(0, 65535));
        end
        total++; if (LED !== 8'h07) begin bad++; $display("FAIL stall_led got=%h want=07", LED); end
        total++; if (dbg_hold_cnt_o !== 16'd4799) begin bad++; $display("FAIL stall_hold got=%0d want=4799", dbg_hold_cnt_o); end
        total++; if (dbg_peak_o !== 15'd1000) begin bad++; $display("FAIL stall_peak got=%0d want=1000", dbg_peak_o); end
        lft_chnnl = '0; rght_chnnl = '0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (LED !== 8'h00) begin bad++; $display("FAIL async_rst_led got=%h want=00", LED); end
        total++; if (dbg_state_o !== S_IDLE) begin bad++; $display("FAIL async_rst_state got=%0d want=0", dbg_state_o); end
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0000, 16'h0100);
        total++; if (dbg_peak_o !== 15'd256) begin bad++; $display("FAIL resume_peak got=%0d want=256", dbg_peak_o); end
    endtask

    task automatic test_random();
        int m_state, m_peak, m_hold, m_dec, mag;
        logic        p_vld;
        logic [15:0] p_l, p_r;
        logic [7:0]  m_led, exp_led;
        apply_reset();
        m_state = 0; m_peak = 0; m_hold = 0; m_dec = 0; m_led = 8'h00;
        p_vld = 1'b0; p_l = '0; p_r = '0;
        for (int c = 0; c < 7400; c++) begin
            @(negedge clk);
            // reference for the edge just taken with the previous inputs
            exp_q.push_back(thermo(m_peak));
            if (p_vld) begin
                mag = (absv(p_l) > absv(p_r)) ? absv(p_l) : absv(p_r);
                if (mag != 0 && mag >= m_peak) begin
                    m_peak = mag; m_hold = 4799; m_dec = 0; m_state = 1;
                end else if (m_state == 1) begin
                    if (m_hold == 0) begin m_state = 2; m_dec = 0; end
                    else m_hold--;
                end else if (m_state == 2) begin
                    if (m_dec == 47) begin
                        m_dec = 0;
                        if (m_peak > 64) m_peak -= 64;
                        else begin m_peak = 0; m_state = 0; end
                    end else m_dec++;
                end
            end
            exp_led = exp_q.pop_front();
            total++;
            if (LED !== exp_led || ((({1'b0, LED} + 9'd1) & {1'b0, LED}) != 9'd0)) begin
                bad++; $display("FAIL rand_led c=%0d got=%b want=%b", c, LED, exp_led);
            end
            total++;
            if (dbg_peak_o !== 15'(m_peak)) begin
                bad++; $display("FAIL rand_peak c=%0d got=%0d want=%0d", c, dbg_peak_o, m_peak);
            end
            if (c < 400) begin
                p_vld = ($urandom_range(0, 9) < 7);
                p_l = $urandom_range(0, 1) ? -16'($urandom_range(0, 1500)) : 16'($urandom_range(0, 1500));
                p_r = $urandom_range(0, 1) ? -16'($urandom_range(0, 1500)) : 16'($urandom_range(0, 1500));
            end else begin
                p_vld = ($urandom_range(0, 19) != 0);
                p_l = $urandom_range(0, 1) ? -16'($urandom_range(0, 20)) : 16'($urandom_range(0, 20));
                p_r = $urandom_range(0, 1) ? -16'($urandom_range(0, 20)) : 16'($urandom_range(0, 20));
            end
            vld = p_vld; lft_chnnl = p_l; rght_chnnl = p_r;
        end
        @(negedge clk);
        vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_thresholds();
        test_decay();
        test_trigger_wins();
        test_stall_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
